mesi_bus_arbiter: RTL and testbench

- Arbitrates the shared snooping bus among N_CPU cache controllers in the MESI system, one transaction at a time.
- Grants one requester and broadcasts its 5-bit CPU event to every other cache's snooper for exactly one clock.
- Gates each snooper via its Controle input.
- Sequences the memory side: optional write-back from a Modified owner, then the block fetch.

---
 rtl/mesi_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 tb/tb_mesi_bus_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesi_bus_arbiter.sv
// Snooping-bus arbiter for the MESI cache system.
// Grants one cache at a time (round robin), broadcasts its event to the other
// snoopers for a single cycle, then sequences an optional write-back from a
// Modified owner followed by the block fetch. Every output is a register.
module mesi_bus_arbiter #(
    parameter int N_CPU = 4
) (
    input  logic               CLK,
    input  logic               CLR,
    input  logic [N_CPU-1:0]   req,
    input  logic [5*N_CPU-1:0] req_event,
    input  logic [3*N_CPU-1:0] snoop_state,
    output logic [N_CPU-1:0]   grant,
    output logic [N_CPU-1:0]   controle,
    output logic [4:0]         snoop_event,
    output logic [N_CPU-1:0]   wb_sel,
    output logic               mem_req,
    output logic               mem_we,
    input  logic               mem_ack,
    output logic [N_CPU-1:0]   done,
    output logic               error,
    output logic               busy
);

    localparam int IW = $clog2(N_CPU);

    // Event encoding {inv,wh,wm,rh,rm}
    localparam logic [4:0] EV_RM  = 5'b00001;
    localparam logic [4:0] EV_RH  = 5'b00010;
    localparam logic [4:0] EV_WM  = 5'b00100;

    localparam logic [2:0]       ST_MODIFIED = 3'b100;
    localparam logic [N_CPU-1:0] ONE_N       = N_CPU'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BCAST,
        S_WB,
        S_MEM,
        S_DONE
    } state_t;

    // Architectural state
    state_t           r_state;
    logic [IW-1:0]    r_rr_ptr;
    logic [4:0]       r_ev;
    logic [N_CPU-1:0] r_owner;

    // Registered outputs
    logic [N_CPU-1:0] r_grant;
    logic [N_CPU-1:0] r_controle;
    logic [4:0]       r_snoop_event;
    logic [N_CPU-1:0] r_wb_sel;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [N_CPU-1:0] r_done;
    logic             r_error;
    logic             r_busy;

    // Next-state values
    state_t           w_state_next;
    logic [IW-1:0]    w_rr_ptr_next;
    logic [4:0]       w_ev_next;
    logic [N_CPU-1:0] w_owner_next;
    logic [N_CPU-1:0] w_grant_next;
    logic [N_CPU-1:0] w_controle_next;
    logic [4:0]       w_snoop_event_next;
    logic [N_CPU-1:0] w_wb_sel_next;
    logic             w_mem_req_next;
    logic             w_mem_we_next;
    logic [N_CPU-1:0] w_done_next;
    logic             w_error_next;

    // Per-cache decode
    logic [4:0]       w_req_ev [N_CPU];
    logic [N_CPU-1:0] w_is_mod;

    // Arbitration / owner helpers
    logic             w_hi_found;
    logic [IW-1:0]    w_hi_idx;
    logic [IW-1:0]    w_lo_idx;
    logic [IW-1:0]    w_winner;
    logic [N_CPU-1:0] w_winner_oh;
    logic [4:0]       w_win_ev;
    logic             w_win_ev_onehot;
    logic [N_CPU-1:0] w_owner_low;
    logic             w_multi_owner;

    // Slice the packed per-cache buses; a Modified owner must not be the requester
    generate
        for (genvar gi = 0; gi < N_CPU; gi++) begin : g_cache
            assign w_req_ev[gi] = req_event[5*gi +: 5];
            assign w_is_mod[gi] = (snoop_state[3*gi +: 3] == ST_MODIFIED) && !r_grant[gi];
        end
    endgenerate

    // Round-robin pick: lowest requester above rr_ptr, else lowest requester overall
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int k = N_CPU - 1; k >= 0; k--) begin
            if (req[k]) begin
                w_lo_idx = IW'(k);
                if (k > int'(r_rr_ptr)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = IW'(k);
                end
            end
        end
        w_winner = w_hi_found ? w_hi_idx : w_lo_idx;
    end

    assign w_winner_oh     = ONE_N << w_winner;
    assign w_win_ev        = w_req_ev[w_winner];
    assign w_win_ev_onehot = (w_win_ev != 5'b0) && ((w_win_ev & (w_win_ev - 5'd1)) == 5'b0);

    // Lowest-index Modified owner; more than one set bit is a protocol violation
    assign w_owner_low   = w_is_mod & (~w_is_mod + ONE_N);
    assign w_multi_owner = |(w_is_mod & (w_is_mod - ONE_N));

    // Next-state and next-output decode for the transaction sequencer
    always_comb begin
        w_state_next       = r_state;
        w_rr_ptr_next      = r_rr_ptr;
        w_ev_next          = r_ev;
        w_owner_next       = r_owner;
        w_grant_next       = r_grant;
        w_controle_next    = '1;
        w_snoop_event_next = '0;
        w_wb_sel_next      = '0;
        w_mem_req_next     = 1'b0;
        w_mem_we_next      = 1'b0;
        w_done_next        = '0;
        w_error_next       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_grant_next  = w_winner_oh;
                    w_rr_ptr_next = w_winner;
                    w_ev_next     = w_win_ev;
                    if (w_win_ev == EV_RH) begin
                        // Read hit needs no bus operation
                        w_state_next = S_DONE;
                    end else if (!w_win_ev_onehot) begin
                        w_error_next = 1'b1;
                        w_state_next = S_DONE;
                    end else begin
                        // Outputs for the broadcast cycle: only the requester's snooper is masked
                        w_state_next       = S_BCAST;
                        w_snoop_event_next = w_win_ev;
                        w_controle_next    = w_winner_oh;
                    end
                end
            end

            S_BCAST: begin
                w_owner_next = w_owner_low;
                w_error_next = w_multi_owner;
                case (r_ev)
                    EV_RM, EV_WM: begin
                        w_mem_req_next = 1'b1;
                        if (|w_owner_low) begin
                            w_state_next  = S_WB;
                            w_mem_we_next = 1'b1;
                            w_wb_sel_next = w_owner_low;
                        end else begin
                            w_state_next = S_MEM;
                        end
                    end
                    default: begin
                        w_state_next = S_DONE;
                    end
                endcase
            end

            S_WB: begin
                w_mem_req_next = 1'b1;
                if (mem_ack) begin
                    w_state_next = S_MEM;
                end else begin
                    w_mem_we_next = 1'b1;
                    w_wb_sel_next = r_owner;
                end
            end

            S_MEM: begin
                if (mem_ack) begin
                    w_state_next = S_DONE;
                end else begin
                    w_mem_req_next = 1'b1;
                end
            end

            S_DONE: begin
                w_done_next  = r_grant;
                w_grant_next = '0;
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
                w_grant_next = '0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight transaction
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= IW'(N_CPU - 1);
            r_ev          <= '0;
            r_owner       <= '0;
            r_grant       <= '0;
            r_controle    <= '1;
            r_snoop_event <= '0;
            r_wb_sel      <= '0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_done        <= '0;
            r_error       <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_rr_ptr      <= w_rr_ptr_next;
            r_ev          <= w_ev_next;
            r_owner       <= w_owner_next;
            r_grant       <= w_grant_next;
            r_controle    <= w_controle_next;
            r_snoop_event <= w_snoop_event_next;
            r_wb_sel      <= w_wb_sel_next;
            r_mem_req     <= w_mem_req_next;
            r_mem_we      <= w_mem_we_next;
            r_done        <= w_done_next;
            r_error       <= w_error_next;
            r_busy        <= (w_state_next != S_IDLE);
        end
    end

    assign grant       = r_grant;
    assign controle    = r_controle;
    assign snoop_event = r_snoop_event;
    assign wb_sel      = r_wb_sel;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign done        = r_done;
    assign error       = r_error;
    assign busy        = r_busy;

endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// Scoreboard bench for mesi_bus_arbiter: a transaction-level model predicts the
// grant order and bus behaviour of each request batch; a monitor reconstructs
// each transaction from the pins and compares it when done pulses.
module tb_mesi_bus_arbiter;

    localparam int N = 4;
    localparam int K_RH  = 0;   // read hit, no bus activity
    localparam int K_BAD = 1;   // malformed event
    localparam int K_SNP = 2;   // broadcast only (inv / wh)
    localparam int K_MEM = 3;   // broadcast + fetch
    localparam int K_WB  = 4;   // broadcast + write-back + fetch

    logic           CLK = 1'b0;
    logic           CLR = 1'b0;
    logic [N-1:0]   req = '0;
    logic [5*N-1:0] req_event = '0;
    logic [3*N-1:0] snoop_state = '0;
    logic           mem_ack = 1'b0;
    logic [N-1:0]   grant, controle, wb_sel, done;
    logic [4:0]     snoop_event;
    logic           mem_req, mem_we, error, busy;

    mesi_bus_arbiter #(.N_CPU(N)) dut (
        .CLK         (CLK),
        .CLR         (CLR),
        .req         (req),
        .req_event   (req_event),
        .snoop_state (snoop_state),
        .grant       (grant),
        .controle    (controle),
        .snoop_event (snoop_event),
        .wb_sel      (wb_sel),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_ack     (mem_ack),
        .done        (done),
        .error       (error),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int           winner;
        logic [4:0]   ev;
        int           kind;
        logic [N-1:0] owner;
        int           err;
    } exp_t;

    exp_t       sb_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         model_ptr = N - 1;
    int         ack_fixed = 0;
    int         spurious_en = 0;
    logic [4:0] ev_tab [N];
    logic [2:0] snoop_tab [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_tabs();
        for (int i = 0; i < N; i++) begin
            req_event[5*i +: 5]   = ev_tab[i];
            snoop_state[3*i +: 3] = snoop_tab[i];
        end
    endtask

    // Reference model: serve the batch in round-robin order, classify each winner
    task automatic model_batch(input logic [N-1:0] mask_in);
        logic [N-1:0] mask;
        exp_t e;
        int w;
        int c;
        int nmod;
        mask = mask_in;
        while (mask != '0) begin
            w = -1;
            for (int k = 1; k <= N; k++) begin
                c = (model_ptr + k) % N;
                if (w < 0 && mask[c]) w = c;
            end
            model_ptr = w;
            mask[w] = 1'b0;
            nmod = 0;
            e.owner = '0;
            for (int j = 0; j < N; j++) begin
                if (j != w && snoop_tab[j] == 3'b100) begin
                    if (nmod == 0) e.owner[j] = 1'b1;
                    nmod++;
                end
            end
            e.winner = w;
            e.ev = ev_tab[w];
            e.err = 0;
            if (e.ev == 5'b00010) begin
                e.kind = K_RH;
            end else if ($countones(e.ev) != 1) begin
                e.kind = K_BAD;
                e.err = 1;
            end else begin
                e.err = (nmod > 1) ? 1 : 0;
                if (e.ev == 5'b00001 || e.ev == 5'b00100)
                    e.kind = (nmod > 0) ? K_WB : K_MEM;
                else
                    e.kind = K_SNP;
            end
            sb_q.push_back(e);
        end
    endtask

    // Memory responder: acks each access after a chosen delay, plus stray acks when idle
    int ack_cnt = -1;
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            mem_ack = 1'b0;
            if (mem_req) begin
                if (ack_cnt < 0) ack_cnt = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(0, 3));
                if (ack_cnt == 0) begin
                    mem_ack = 1'b1;
                    ack_cnt = -1;
                end else begin
                    ack_cnt--;
                end
            end else begin
                ack_cnt = -1;
                if (spurious_en != 0 && $urandom_range(0, 7) == 0) mem_ack = 1'b1;
            end
        end
    end

    // Monitor: rebuild each transaction from grant to done and score it
    bit           active = 1'b0;
    int           cyc, bc, wb_c, mem_c, wb_a, mem_a, errs;
    logic [N-1:0] t_grant, t_ctl, t_wbsel;
    logic [4:0]   t_sev;
    initial begin
        exp_t e;
        int base;
        int phases;
        forever begin
            @(negedge CLK);
            if (!CLR) begin
                active = 1'b0;
            end else begin
                chk("busy_vs_grant", busy, (grant != '0));
                chk("controle_vs_event", (controle != '1), (snoop_event != 5'b0));
                if (wb_sel != '0) chk("wb_sel_outside_wb", (mem_req && mem_we), 1);

                if (!active && grant != '0) begin
                    active = 1'b1;
                    t_grant = grant;
                    cyc = 0; bc = 0; wb_c = 0; mem_c = 0; wb_a = 0; mem_a = 0; errs = 0;
                    t_ctl = '0; t_wbsel = '0; t_sev = '0;
                end else if (active) begin
                    cyc++;
                end

                if (active) begin
                    if (controle != '1) begin
                        bc++;
                        t_sev = snoop_event;
                        t_ctl = controle;
                    end
                    if (mem_req) begin
                        if (mem_we) begin
                            wb_c++;
                            t_wbsel = wb_sel;
                            if (mem_ack) wb_a++;
                        end else begin
                            mem_c++;
                            if (mem_ack) mem_a++;
                        end
                    end
                    if (error) errs++;
                    if (done != '0) begin
                        active = 1'b0;
                        if (sb_q.size() == 0) begin
                            chk("unexpected_done", done, 0);
                        end else begin
                            e = sb_q.pop_front();
                            base   = (e.kind == K_WB) ? 4 : (e.kind == K_MEM) ? 3 : (e.kind == K_SNP) ? 2 : 1;
                            phases = (e.kind == K_WB) ? 2 : (e.kind == K_MEM) ? 1 : 0;
                            chk("done_idx", done, 32'd1 << e.winner);
                            chk("grant_idx", t_grant, 32'd1 << e.winner);
                            chk("grant_clear_at_done", grant, 0);
                            chk("bcast_cycles", bc, (e.kind >= K_SNP) ? 1 : 0);
                            if (bc != 0) begin
                                chk("snoop_event", t_sev, e.ev);
                                chk("controle_bcast", t_ctl, 32'd1 << e.winner);
                            end
                            chk("error_pulses", errs, e.err);
                            chk("wb_phase", (wb_c != 0), (e.kind == K_WB));
                            chk("mem_phase", (mem_c != 0), (e.kind >= K_MEM));
                            if (e.kind == K_WB) begin
                                chk("wb_sel", t_wbsel, e.owner);
                                chk("wb_acks", wb_a, 1);
                            end
                            if (e.kind >= K_MEM) chk("mem_acks", mem_a, 1);
                            chk("latency", cyc, base + wb_c + mem_c - phases);
                            $display("txn cache=%0d ev=%b kind=%0d err=%0d wb=%0d mem=%0d lat=%0d",
                                     e.winner, e.ev, e.kind, errs, wb_c, mem_c, cyc);
                        end
                    end
                end else begin
                    chk("idle_quiet", {done != '0, error, mem_req}, 0);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_controle"}, controle, 32'hF);
        chk({tag, "_snoop_event"}, snoop_event, 0);
        chk({tag, "_wb_sel"}, wb_sel, 0);
        chk({tag, "_mem"}, {mem_req, mem_we}, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error_busy"}, {error, busy}, 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #2;
        CLR = 1'b0;
        req = '0;
        #1;
        check_reset_outputs("rst");
        sb_q.delete();
        model_ptr = N - 1;
        repeat (2) @(negedge CLK);
        #2;
        CLR = 1'b1;
    endtask

    // Issue a batch of requests; drop each request on its done (or once fetching, in mode 1)
    task automatic run_batch(input logic [N-1:0] mask, input int dmode);
        bit ok;
        model_batch(mask);
        req = mask;
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            if (dmode == 1 && mem_req && !mem_we) req = req & ~grant;
            if (done != '0) req = req & ~done;
            if (req == '0 && sb_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("batch_complete", ok, 1);
        if (!ok) do_reset();
    endtask

    task automatic set_all(input logic [4:0] ev, input logic [2:0] st);
        for (int i = 0; i < N; i++) begin
            ev_tab[i] = ev;
            snoop_tab[i] = st;
        end
    endtask

    initial begin
        logic [2:0] codes [4];
        bit reached;
        codes[0] = 3'b001; codes[1] = 3'b010; codes[2] = 3'b011; codes[3] = 3'b100;

        set_all(5'b00001, 3'b010);
        apply_tabs();
        repeat (3) @(negedge CLK);
        check_reset_outputs("por");
        #2;
        CLR = 1'b1;
        @(negedge CLK);

        // Two requesters, read misses, no owners, immediate acks
        ack_fixed = 0;
        set_all(5'b00001, 3'b010);
        apply_tabs();
        run_batch(4'b0110, 0);

        // Read miss with a Modified owner at cache 2
        set_all(5'b00001, 3'b010);
        snoop_tab[2] = 3'b100;
        apply_tabs();
        run_batch(4'b0001, 0);

        // Invalidate from cache 3
        set_all(5'b00001, 3'b010);
        ev_tab[3] = 5'b10000;
        apply_tabs();
        run_batch(4'b1000, 0);

        // Malformed event from cache 1
        set_all(5'b00001, 3'b010);
        ev_tab[1] = 5'b00110;
        apply_tabs();
        run_batch(4'b0010, 0);

        // Write miss from cache 3 with two Modified owners
        set_all(5'b00001, 3'b010);
        ev_tab[3] = 5'b00100;
        snoop_tab[0] = 3'b100;
        snoop_tab[2] = 3'b100;
        apply_tabs();
        run_batch(4'b1000, 0);

        // Read hit
        set_all(5'b00010, 3'b011);
        apply_tabs();
        run_batch(4'b0100, 0);

        // Slow memory, request dropped while fetching
        ack_fixed = 5;
        set_all(5'b00100, 3'b010);
        apply_tabs();
        run_batch(4'b0001, 1);

        // Reset while a write-back is pending
        ack_fixed = 20;
        set_all(5'b00001, 3'b010);
        snoop_tab[2] = 3'b100;
        apply_tabs();
        req = 4'b0001;
        reached = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (mem_req && mem_we) begin
                reached = 1'b1;
                break;
            end
        end
        chk("reach_wb", reached, 1);
        chk("wb_sel_before_reset", wb_sel, 4'b0100);
        do_reset();
        ack_fixed = 0;
        set_all(5'b00001, 3'b010);
        apply_tabs();
        run_batch(4'b1111, 0);

        // Randomised batches
        ack_fixed = -1;
        spurious_en = 1;
        for (int b = 0; b < 60; b++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 4) == 0)
                    ev_tab[i] = 5'($urandom_range(0, 31));
                else
                    ev_tab[i] = 5'b00001 << $urandom_range(0, 4);
                snoop_tab[i] = codes[$urandom_range(0, 3)];
            end
            apply_tabs();
            run_batch(4'($urandom_range(1, 15)), int'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog expired");
    end

endmodule
